// File: rtl/audio_sample_pacer.sv
// Stereo sample FIFO drained at a fixed tick rate into registered PWM duty values.
// Optional: define AUDIO_PACER_UNDERRUN_MUTE_EN to force midscale output on an underrun tick.
module audio_sample_pacer #(
   parameter int DEPTH    = 8,
   parameter int TICK_DIV = 256
) (
   input  logic                     clk,
   input  logic                     aclr,
   input  logic                     enable,
   input  logic                     s_valid,
   input  logic [7:0]               s_left,
   input  logic [7:0]               s_right,
   output logic                     s_ready,
   output logic [7:0]               left_top,
   output logic [7:0]               right_top,
   output logic                     sample_strobe,
   output logic                     underrun,
   input  logic                     underrun_clr,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
   localparam logic [PW:0]   FULL    = (PW + 1)'(DEPTH);
   localparam logic [7:0]    MID     = 8'h80;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   fill_q, fill_d;
   logic [7:0]    left_q, left_d, right_q, right_d;
   logic          strobe_q, urun_q, urun_d;
   logic [15:0]   mem_q [DEPTH];

   logic tick, push, pop, urun_ev;

   // Pop decisions use registered occupancy only, so a pair pushed on a tick edge is never bypassed.
   always_comb begin
      tick     = enable && (cnt_q == CNT_MAX);
      push     = s_valid && s_ready;
      pop      = tick && (fill_q != '0);
      urun_ev  = tick && (fill_q == '0);

      cnt_d    = '0;
      if (enable && !tick) cnt_d = cnt_q + CW'(1);

      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

      fill_d   = fill_q;
      case ({push, pop})
         2'b10:   fill_d = fill_q + (PW + 1)'(1);
         2'b01:   fill_d = fill_q - (PW + 1)'(1);
         default: fill_d = fill_q;
      endcase

      left_d   = left_q;
      right_d  = right_q;
      if (pop) begin
         left_d  = mem_q[rd_ptr_q][15:8];
         right_d = mem_q[rd_ptr_q][7:0];
      end
`ifdef AUDIO_PACER_UNDERRUN_MUTE_EN
      else if (urun_ev) begin
         left_d  = MID;
         right_d = MID;
      end
`else
`endif

      // A coincident clear loses to a new underrun.
      urun_d   = urun_q;
      if (urun_ev)           urun_d = 1'b1;
      else if (underrun_clr) urun_d = 1'b0;
   end

   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         left_q   <= MID;
         right_q  <= MID;
         strobe_q <= 1'b0;
         urun_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         left_q   <= left_d;
         right_q  <= right_d;
         strobe_q <= pop;
         urun_q   <= urun_d;
      end
   end

   // Storage needs no reset; occupancy and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {s_left, s_right};
   end

   assign s_ready       = (fill_q < FULL);
   assign fill          = fill_q;
   assign left_top      = left_q;
   assign right_top     = right_q;
   assign sample_strobe = strobe_q;
   assign underrun      = urun_q;

endmodule
